// File: rtl/adc_align_pkg.sv
// adc_align_pkg: shared types and constants for the ADC frame aligner.
//   - align_state_e : 3-bit state encoding of the alignment controller
//   - FRAME_DEFAULT : expected deserialized frame word
//   - widths of SLIPCNT, RELOCKS, ERRCNT and the internal timing counters
//   - default timing constants (settle time, match/loss thresholds, slip limit)
package adc_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_e;

  localparam int unsigned          FRAME_W       = 6;
  localparam logic [FRAME_W-1:0]   FRAME_DEFAULT = 6'b111000;

  localparam int unsigned SLIPCNT_W = 4;
  localparam int unsigned RELOCKS_W = 8;
  localparam int unsigned ERRCNT_W  = 16;
  localparam int unsigned CNT_W     = 8;  // settle / match / miss counters (thresholds 1..255)

  localparam int unsigned SETTLE_CYC_DEFAULT = 15;
  localparam int unsigned MATCH_N_DEFAULT    = 16;
  localparam int unsigned LOSS_N_DEFAULT     = 4;
  localparam int unsigned MAX_SLIP_DEFAULT   = 12;

endpackage

// File: rtl/adc_align_satcnt.sv
// adc_align_satcnt: W-bit up counter that sticks at all-ones.
//   clk  in  clock
//   rst  in  synchronous active-high reset (to zero)
//   clr  in  synchronous clear, wins over inc
//   inc  in  count enable
//   cnt  out current count
module adc_align_satcnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/adc_frame_align.sv
// adc_frame_align: bit-slip sequencing controller for the 8-lane ADC
// deserializer. Compares the deserialized frame word against FRAME, issues
// one-cycle bit-slip pulses until the word is stable, then watches for loss
// of lock.
//   CLK      in  clock (deserializer output clock)
//   RST      in  synchronous active-high reset, highest priority
//   START    in  one-cycle (re)start request
//   FR       in  deserialized frame word
//   BS       out bit-slip pulse, high only in SLIP
//   LOCKED   out high only in LOCKED
//   FAIL     out high only in FAIL (sticky until START/RST)
//   SLIPCNT  out slips issued in the current attempt
//   RELOCKS  out lock-loss events since reset, saturating
//   ERRCNT   out (only with ADC_ALIGN_ERRCNT_EN) mismatching words seen while
//                locked, saturating, cleared by START
// Optional feature macro: ADC_ALIGN_ERRCNT_EN
module adc_frame_align
  import adc_align_pkg::*;
#(
  parameter logic [FRAME_W-1:0] FRAME      = FRAME_DEFAULT,
  parameter int unsigned        SETTLE_CYC = SETTLE_CYC_DEFAULT,
  parameter int unsigned        MATCH_N    = MATCH_N_DEFAULT,
  parameter int unsigned        LOSS_N     = LOSS_N_DEFAULT,
  parameter int unsigned        MAX_SLIP   = MAX_SLIP_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [FRAME_W-1:0]   FR,
  output logic                 BS,
  output logic                 LOCKED,
  output logic                 FAIL,
  output logic [SLIPCNT_W-1:0] SLIPCNT,
  output logic [RELOCKS_W-1:0] RELOCKS
`ifdef ADC_ALIGN_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]  ERRCNT
`endif
);

  localparam logic [CNT_W-1:0]     SETTLE_LD  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]     MATCH_LAST = CNT_W'(MATCH_N - 1);
  localparam logic [CNT_W-1:0]     LOSS_LAST  = CNT_W'(LOSS_N - 1);
  localparam logic [SLIPCNT_W-1:0] SLIP_LIMIT = SLIPCNT_W'(MAX_SLIP);

  align_state_e         state_q, state_d;
  logic [CNT_W-1:0]     settle_q, settle_d;
  logic [CNT_W-1:0]     match_q, match_d;
  logic [CNT_W-1:0]     miss_q, miss_d;
  logic [SLIPCNT_W-1:0] slipcnt_q, slipcnt_d;
  logic                 bs_q, bs_d;
  logic                 locked_q, locked_d;
  logic                 fail_q, fail_d;
  logic                 relock_inc;
  logic                 frame_ok;

  assign frame_ok = (FR == FRAME);

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    match_d    = match_q;
    miss_d     = miss_q;
    slipcnt_d  = slipcnt_q;
    relock_inc = 1'b0;

    if (START) begin
      state_d   = ST_SETTLE;
      settle_d  = SETTLE_LD;
      match_d   = '0;
      miss_d    = '0;
      slipcnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_d = ST_CHECK;
            match_d = '0;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        ST_CHECK: begin
          if (frame_ok) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            // SLIPCNT steps together with the BS pulse so the SLIP state can
            // decide FAIL from the already-updated count.
            state_d   = ST_SLIP;
            slipcnt_d = slipcnt_q + 1'b1;
            match_d   = '0;
          end
        end
        ST_SLIP: begin
          if (slipcnt_q == SLIP_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LD;
          end
        end
        ST_LOCKED: begin
          if (frame_ok) begin
            miss_d = '0;
          end else if (miss_q == LOSS_LAST) begin
            state_d    = ST_SETTLE;
            settle_d   = SETTLE_LD;
            match_d    = '0;
            miss_d     = '0;
            slipcnt_d  = '0;
            relock_inc = 1'b1;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end

    // Status flops are loaded from the next state so they line up with state_q.
    bs_d     = (state_d == ST_SLIP);
    locked_d = (state_d == ST_LOCKED);
    fail_d   = (state_d == ST_FAIL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      slipcnt_q <= '0;
      bs_q      <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      slipcnt_q <= slipcnt_d;
      bs_q      <= bs_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end

  assign BS      = bs_q;
  assign LOCKED  = locked_q;
  assign FAIL    = fail_q;
  assign SLIPCNT = slipcnt_q;

  adc_align_satcnt #(.W(RELOCKS_W)) u_relocks (
    .clk (CLK),
    .rst (RST),
    .clr (1'b0),
    .inc (relock_inc),
    .cnt (RELOCKS)
  );

`ifdef ADC_ALIGN_ERRCNT_EN
  logic err_inc;

  assign err_inc = (state_q == ST_LOCKED) && !frame_ok && !START;

  adc_align_satcnt #(.W(ERRCNT_W)) u_errcnt (
    .clk (CLK),
    .rst (RST),
    .clr (START),
    .inc (err_inc),
    .cnt (ERRCNT)
  );
`else
  // Error counter not built.
`endif

endmodule
